i2s_rx_deser: RTL and testbench

I2S_RX_DESER -- requirements
Module: i2s_rx_deser

---
 rtl/audio_in_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/i2s_rx_deser.sv | 183 ++++++++++++++++++
 tb/tb_i2s_rx_deser.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_in_pkg.sv
// Shared definitions for the audio input path: receiver state encoding and
// default sample/slot widths.
package audio_in_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;
    localparam int DEFAULT_SLOT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MSB = 2'd1,
        SHIFT    = 2'd2,
        HOLD     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing a single asynchronous bit into the
// ACLK domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA with ACLK, deserializes the left
// and right words MSB first and presents stereo pairs on a valid/ready port.
// Optional macro I2S_RX_OVERRUN_CNT_EN adds a 16-bit saturating overrun_cnt
// output counting dropped pairs.
module i2s_rx_deser
    import audio_in_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SLOT_WIDTH = DEFAULT_SLOT_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_left,
    output logic [DATA_WIDTH-1:0] m_right,
    output logic                  overrun,
    output logic                  short_slot
`ifdef I2S_RX_OVERRUN_CNT_EN
    ,
    output logic [15:0]           overrun_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    // A slot narrower than the nominal slot can never carry more than
    // SLOT_WIDTH bits, so that is the most a short-slot check may demand.
    localparam int FULL_BITS = (DATA_WIDTH < SLOT_WIDTH) ? DATA_WIDTH : SLOT_WIDTH;

    logic bclk_s;
    logic lrclk_s;
    logic sdata_s;
    logic bclk_d;
    logic bit_tick;
    logic lrclk_prev;
    logic lr_change;

    rx_state_t state_q;
    rx_state_t state_d;

    // Only DATA_WIDTH-1 bits of history are kept; the final bit goes straight
    // from the synchronizer into the completed word.
    logic [DATA_WIDTH-2:0] shift_q;
    logic [DATA_WIDTH-2:0] shift_d;
    logic [DATA_WIDTH-1:0] shift_in;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W-1:0]      fill;
    logic                  chan_q;
    logic                  chan_d;
    logic                  word_done;
    logic                  word_short;
    logic [DATA_WIDTH-1:0] word_out;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  pair_done;

    sync_2ff u_sync_bclk  (.clk(ACLK), .rst_n(ARESETN), .d(i2s_bclk),  .q(bclk_s));
    sync_2ff u_sync_lrclk (.clk(ACLK), .rst_n(ARESETN), .d(i2s_lrclk), .q(lrclk_s));
    sync_2ff u_sync_sdata (.clk(ACLK), .rst_n(ARESETN), .d(i2s_sdata), .q(sdata_s));

    assign bit_tick  = bclk_s & ~bclk_d;
    assign lr_change = lrclk_s ^ lrclk_prev;
    assign shift_in  = {shift_q, sdata_s};
    assign cnt_inc   = (cnt_q < CNT_W'(DATA_WIDTH)) ? cnt_q + CNT_W'(1) : cnt_q;
    // Left-justify whatever arrived so missing LSBs read as zero
    assign fill      = CNT_W'(DATA_WIDTH) - cnt_inc;
    assign word_out  = shift_in << fill;
    assign pair_done = word_done & chan_q;

    // Edge-detect flop, last-seen word select, and the receiver state registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bclk_d     <= 1'b0;
            lrclk_prev <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            chan_q     <= 1'b0;
        end else begin
            bclk_d  <= bclk_s;
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            if (bit_tick) begin
                lrclk_prev <= lrclk_s;
            end
        end
    end

    // Slot sequencing: align on a left slot, skip the delay bit, shift, close
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        chan_d     = chan_q;
        word_done  = 1'b0;
        word_short = 1'b0;
        if (bit_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (lrclk_prev && !lrclk_s) begin
                        state_d = WAIT_MSB;
                        chan_d  = 1'b0;
                    end
                end
                WAIT_MSB: begin
                    shift_d = {{(DATA_WIDTH-2){1'b0}}, sdata_s};
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    // The tick that sees the word-select change still carries
                    // the previous slot's LSB, so it is shifted before closing.
                    shift_d = shift_in[DATA_WIDTH-2:0];
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
                        word_done = 1'b1;
                        state_d   = HOLD;
                    end
                    if (lr_change) begin
                        word_done  = 1'b1;
                        word_short = (cnt_inc < CNT_W'(FULL_BITS));
                        state_d    = WAIT_MSB;
                        chan_d     = lrclk_s;
                    end
                end
                HOLD: begin
                    if (lr_change) begin
                        state_d = WAIT_MSB;
                        chan_d  = lrclk_s;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Left word holding, pair hand-off with backpressure, and status pulses
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            left_hold  <= '0;
            m_valid    <= 1'b0;
            m_left     <= '0;
            m_right    <= '0;
            overrun    <= 1'b0;
            short_slot <= 1'b0;
        end else begin
            overrun    <= 1'b0;
            short_slot <= word_done & word_short;
            if (word_done && !chan_q) begin
                left_hold <= word_out;
            end
            if (pair_done) begin
                if (!m_valid || m_ready) begin
                    m_left  <= left_hold;
                    m_right <= word_out;
                    m_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVERRUN_CNT_EN
    // Tally dropped pairs, sticking at all-ones rather than wrapping
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            overrun_cnt <= '0;
        end else if (overrun && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: drives I2S frames from a bit-level generator and
// compares received pairs and status pulses against a word-level model.
module tb_i2s_rx_deser;

    localparam int DW = 24;
    localparam int SW = 32;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          ACLK      = 1'b0;
    logic          ARESETN   = 1'b0;
    logic          i2s_bclk  = 1'b1;
    logic          i2s_lrclk = 1'b1;
    logic          i2s_sdata = 1'b0;
    logic          m_ready   = 1'b1;
    logic          m_valid;
    logic [DW-1:0] m_left;
    logic [DW-1:0] m_right;
    logic          overrun;
    logic          short_slot;
`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [15:0]   overrun_cnt;
`endif

    int    total     = 0;
    int    bad       = 0;
    int    ov_seen   = 0;
    int    sh_seen   = 0;
    int    exp_sh    = 0;
    logic  carry_bit = 1'b0;
    pair_t exp_q[$];

    i2s_rx_deser #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdata  (i2s_sdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_left     (m_left),
        .m_right    (m_right),
        .overrun    (overrun),
        .short_slot (short_slot)
`ifdef I2S_RX_OVERRUN_CNT_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Bit j of a slot's serial content: the word MSB first, zeros after it
    function automatic logic slot_bit(input logic [31:0] word, input int bits, input int j);
        if (j >= 0 && j < bits) return word[bits-1-j];
        return 1'b0;
    endfunction

    // Word the receiver should report: the first DW bits of the slot, left-justified
    function automatic logic [DW-1:0] expect_word(input logic [31:0] word, input int bits, input int slot_len);
        logic [DW-1:0] w;
        w = '0;
        for (int j = 0; j < slot_len && j < DW; j++) w[DW-1-j] = slot_bit(word, bits, j);
        return w;
    endfunction

    task automatic send_cycle(input logic lr, input logic sd);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sdata = sd;
        #22;
        i2s_bclk  = 1'b1;
        #22;
    endtask

    // One slot with the standard one-bit delay after the word-select change
    task automatic send_slot(input logic lr, input logic [31:0] word, input int bits, input int slot_len);
        for (int c = 0; c < slot_len; c++) begin
            send_cycle(lr, (c == 0) ? carry_bit : slot_bit(word, bits, c - 1));
        end
        carry_bit = slot_bit(word, bits, slot_len - 1);
    endtask

    task automatic applyStimulus(input logic [31:0] lw, input int lb, input int ls,
                                 input logic [31:0] rw, input int rb, input int rs,
                                 input bit keep_pair);
        pair_t p;
        if (keep_pair) begin
            p.l = expect_word(lw, lb, ls);
            p.r = expect_word(rw, rb, rs);
            exp_q.push_back(p);
        end
        exp_sh += int'(ls < DW) + int'(rs < DW);
        send_slot(1'b0, lw, lb, ls);
        send_slot(1'b1, rw, rb, rs);
    endtask

    task automatic lead_in(input int n);
        for (int i = 0; i < n; i++) send_cycle(1'b1, 1'($urandom));
    endtask

    task automatic set_ready(input logic v);
        @(posedge ACLK);
        #1;
        m_ready = v;
    endtask

    task automatic do_reset(input bit check);
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        if (check) begin
            checkOutput("rst_valid", 32'(m_valid), 0);
            checkOutput("rst_left", 32'(m_left), 0);
            checkOutput("rst_right", 32'(m_right), 0);
            checkOutput("rst_overrun", 32'(overrun), 0);
            checkOutput("rst_short", 32'(short_slot), 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
            checkOutput("rst_ovcnt", 32'(overrun_cnt), 0);
`endif
        end
        @(negedge ACLK);
        exp_q.delete();
        ov_seen   = 0;
        sh_seen   = 0;
        exp_sh    = 0;
        carry_bit = 1'b0;
        ARESETN   = 1'b1;
        repeat (4) @(negedge ACLK);
    endtask

    task automatic finish_scenario(input string tag, input int exp_ov);
        send_slot(1'b0, 32'h0, 0, 3);
        repeat (30) @(negedge ACLK);
        checkOutput({tag, "_pending"}, 32'(exp_q.size()), 0);
        checkOutput({tag, "_overruns"}, 32'(ov_seen), 32'(exp_ov));
        checkOutput({tag, "_shorts"}, 32'(sh_seen), 32'(exp_sh));
    endtask

    // Output monitor: every accepted pair must be the next one the model expects
    initial begin
        pair_t p;
        forever begin
            @(negedge ACLK);
            if (overrun) ov_seen++;
            if (short_slot) sh_seen++;
            if (m_valid && m_ready) begin
                checkOutput("pair_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    p = exp_q.pop_front();
                    checkOutput("pair_left", 32'(m_left), 32'(p.l));
                    checkOutput("pair_right", 32'(m_right), 32'(p.r));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] lw, rw, mask;
        int          lb, ls, rs;

        // Reset values, then the basic reference frame
        do_reset(1'b1);
        lead_in(4);
        applyStimulus(32'hABCDEF, 24, 32, 32'h123456, 24, 32, 1'b1);
        finish_scenario("basic", 0);

        // Randomized frames, including exact-width and short slots
        do_reset(1'b0);
        lead_in(5);
        for (int f = 0; f < 8; f++) begin
            lb = 24;
            ls = $urandom_range(24, 32);
            if ($urandom_range(0, 3) == 0) begin
                ls = $urandom_range(16, 23);
                lb = ls;
            end
            mask = (32'h1 << lb) - 32'h1;
            lw   = $urandom & mask;
            rw   = $urandom & 32'hFF_FFFF;
            rs   = (f == 3) ? 24 : $urandom_range(24, 32);
            applyStimulus(lw, lb, ls, rw, 24, rs, 1'b1);
        end
        finish_scenario("random", 0);

        // Backpressure: second frame dropped, first retained then delivered
        do_reset(1'b0);
        set_ready(1'b0);
        lead_in(4);
        applyStimulus($urandom & 32'hFF_FFFF, 24, 32, $urandom & 32'hFF_FFFF, 24, 32, 1'b1);
        applyStimulus($urandom & 32'hFF_FFFF, 24, 32, $urandom & 32'hFF_FFFF, 24, 32, 1'b0);
        send_slot(1'b0, 32'h0, 0, 3);
        repeat (10) @(negedge ACLK);
        checkOutput("bp_valid", 32'(m_valid), 1);
        checkOutput("bp_left", 32'(m_left), 32'(exp_q[0].l));
        checkOutput("bp_right", 32'(m_right), 32'(exp_q[0].r));
        checkOutput("bp_overruns", 32'(ov_seen), 1);
        set_ready(1'b1);
        finish_scenario("bp", 1);

        // Short left slot of sixteen ones
        do_reset(1'b0);
        lead_in(4);
        applyStimulus(32'hFFFF, 16, 16, $urandom & 32'hFF_FFFF, 24, 32, 1'b1);
        finish_scenario("short", 0);

        // Startup mid-stream: garbage on both channels before the first alignment
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) send_cycle(1'b0, 1'($urandom));
        lead_in(11);
        checkOutput("startup_quiet", 32'(m_valid), 0);
        applyStimulus($urandom & 32'hFF_FFFF, 24, 32, $urandom & 32'hFF_FFFF, 24, 32, 1'b1);
        applyStimulus($urandom & 32'hFF_FFFF, 24, 30, $urandom & 32'hFF_FFFF, 24, 32, 1'b1);
        finish_scenario("startup", 0);

        // Reset in the middle of a left slot with a pair still held on the output
        do_reset(1'b0);
        set_ready(1'b0);
        lead_in(4);
        applyStimulus(32'hA5A5A5, 24, 32, 32'h5A5A5A, 24, 32, 1'b1);
        for (int i = 0; i < 10; i++) send_cycle(1'b0, 1'($urandom));
        do_reset(1'b1);
        set_ready(1'b1);
        for (int i = 0; i < 22; i++) send_cycle(1'b0, 1'($urandom));
        send_slot(1'b1, $urandom & 32'hFF_FFFF, 24, 32);
        applyStimulus($urandom & 32'hFF_FFFF, 24, 32, $urandom & 32'hFF_FFFF, 24, 32, 1'b1);
        applyStimulus($urandom & 32'hFF_FFFF, 24, 32, $urandom & 32'hFF_FFFF, 24, 32, 1'b1);
        finish_scenario("midreset", 0);

`ifdef I2S_RX_OVERRUN_CNT_EN
        // Three dropped pairs must be tallied
        do_reset(1'b0);
        set_ready(1'b0);
        lead_in(4);
        applyStimulus($urandom & 32'hFF_FFFF, 24, 32, $urandom & 32'hFF_FFFF, 24, 32, 1'b1);
        for (int f = 0; f < 3; f++) begin
            applyStimulus($urandom & 32'hFF_FFFF, 24, 32, $urandom & 32'hFF_FFFF, 24, 32, 1'b0);
        end
        send_slot(1'b0, 32'h0, 0, 3);
        repeat (10) @(negedge ACLK);
        checkOutput("ovcnt_value", 32'(overrun_cnt), 3);
        set_ready(1'b1);
        finish_scenario("ovcnt", 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
